// File: rtl/panel_timing_gen.sv
// panel_timing_gen: raster timing generator for the micro-display panel.
// Runs in the panel pixel clock domain. Timing only starts after the PLL has
// shown LOCK_WAIT consecutive locked cycles. When enable drops, the current
// frame is allowed to finish before the generator stops.
//
// Ports:
//   clock       panel pixel clock
//   reset_n     asynchronous active-low reset
//   locked      PLL lock (asynchronous, synchronised internally)
//   enable      request to run timing
//   hsync/vsync sync outputs, asserted level set by HSYNC_POL/VSYNC_POL
//   de          active-pixel data enable
//   x/y         pixel column/row while de=1, otherwise 0
//   line_start  one-cycle pulse at h=0 of each line
//   frame_start one-cycle pulse at h=0, v=0
//   running     high while the raster is being produced
module panel_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 24,
  parameter int H_SYNC    = 16,
  parameter int H_BP      = 120,
  parameter int V_ACTIVE  = 400,
  parameter int V_FP      = 8,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 70,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int LOCK_WAIT = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        locked,
  input  logic        enable,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start,
  output logic        running
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int LCW     = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

  // Counter widths are fixed at 11/10 bits; anything larger cannot be built.
  generate
    if (H_TOTAL > 2048 || V_TOTAL > 1024 || LOCK_WAIT < 1) begin : g_bad_params
      $error("panel_timing_gen: illegal timing parameters");
    end
  endgenerate

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] HA     = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  VA     = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_WAIT - 1);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_LOCK = 2'd1;
  localparam logic [1:0] RUN       = 2'd2;
  localparam logic [1:0] STOPPING  = 2'd3;

  logic           sync1_q, lock_s_q;
  logic [1:0]     state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
  logic [10:0]    h_q, h_d, h_nxt;
  logic [9:0]     v_q, v_d, v_nxt;
  logic           active, out_en, last_pix;
  logic           hsync_d, vsync_d, de_d, line_start_d, frame_start_d, running_d;
  logic [10:0]    x_d;
  logic [9:0]     y_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= locked;
      lock_s_q <= sync1_q;
    end
  end

  always_comb begin
    active   = (state_q == RUN) || (state_q == STOPPING);
    last_pix = (h_q == H_LAST) && (v_q == V_LAST);
    h_nxt    = (h_q == H_LAST) ? 11'd0 : h_q + 11'd1;
    v_nxt    = v_q;
    if (h_q == H_LAST) v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;

    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    h_d        = h_q;
    v_d        = v_q;
    case (state_q)
      IDLE: begin
        if (enable && lock_s_q) begin
          state_d    = WAIT_LOCK;
          lock_cnt_d = '0;
        end
      end
      WAIT_LOCK: begin
        if (!lock_s_q || !enable) begin
          state_d = IDLE;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d = RUN;
          h_d     = 11'd0;
          v_d     = 10'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      RUN: begin
        h_d = h_nxt;
        v_d = v_nxt;
        if (!enable) state_d = STOPPING;
      end
      STOPPING: begin
        // The wrap at the last pixel leaves h=v=0 on the way to IDLE.
        h_d = h_nxt;
        v_d = v_nxt;
        if (enable)        state_d = RUN;
        else if (last_pix) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Lock loss overrides everything while the raster is live.
    if (active && !lock_s_q) begin
      state_d = IDLE;
      h_d     = 11'd0;
      v_d     = 10'd0;
    end
  end

  // Output decode is gated by lock_s as well as state, so the outputs go idle
  // on the same edge the FSM drops to IDLE after a lock loss.
  always_comb begin
    out_en        = active && lock_s_q;
    de_d          = out_en && (h_q < HA) && (v_q < VA);
    x_d           = de_d ? h_q : 11'd0;
    y_d           = de_d ? v_q : 10'd0;
    hsync_d       = (out_en && h_q >= HS_BEG && h_q < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = (out_en && v_q >= VS_BEG && v_q < VS_END) ? VSYNC_POL : ~VSYNC_POL;
    line_start_d  = out_en && (h_q == 11'd0);
    frame_start_d = out_en && (h_q == 11'd0) && (v_q == 10'd0);
    running_d     = out_en;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      lock_cnt_q  <= '0;
      h_q         <= 11'd0;
      v_q         <= 10'd0;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      x           <= 11'd0;
      y           <= 10'd0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      running     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      h_q         <= h_d;
      v_q         <= v_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      x           <= x_d;
      y           <= y_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
      running     <= running_d;
    end
  end
endmodule
